// File: rtl/wide_bit_alu.sv
// Handshaked wide-word ALU: parity, popcount and rotates, with reductions iterated over CHUNK_WIDTH slices.
// Define WIDE_BIT_ALU_CLZ_EN to add count-leading-zeros on opcode 100; otherwise that opcode is illegal.
module wide_bit_alu #(
    parameter int DATA_WIDTH  = 1024,
    parameter int CHUNK_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [2:0]            opcode,
    input  logic [DATA_WIDTH-1:0] A_in,
    input  logic [DATA_WIDTH-1:0] B_in,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_err,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam int NUM_CHUNKS = DATA_WIDTH / CHUNK_WIDTH;
    localparam int ACC_W      = $clog2(DATA_WIDTH + 1);
    localparam int AMT_W      = $clog2(DATA_WIDTH);
    localparam int CNT_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    typedef enum logic [2:0] {
        OP_PARITY   = 3'b000,
        OP_POPCOUNT = 3'b001,
        OP_ROTR     = 3'b010,
        OP_ROTL     = 3'b011,
        OP_CLZ      = 3'b100
    } op_t;

    state_t                  r_state;
    logic [2:0]              r_op;
    logic [DATA_WIDTH-1:0]   r_a;
    logic [AMT_W-1:0]        r_amt;
    logic [CNT_W-1:0]        r_cnt;
    logic [ACC_W-1:0]        r_pop;
    logic                    r_par;
    logic [DATA_WIDTH-1:0]   r_outData;
    logic                    r_outErr;
    logic                    r_outValid;

    logic [CHUNK_WIDTH-1:0]  w_slice;
    logic [ACC_W-1:0]        w_popNext;
    logic                    w_parNext;
    logic                    w_isReduce;
    logic                    w_lastChunk;
    logic [DATA_WIDTH-1:0]   w_rotr;
    logic [DATA_WIDTH-1:0]   w_rotl;
    logic [DATA_WIDTH-1:0]   w_result;
    logic                    w_err;
    logic                    w_unusedBHigh;

    function automatic logic [ACC_W-1:0] slicePop(input logic [CHUNK_WIDTH-1:0] s);
        logic [ACC_W-1:0] c;
        c = '0;
        for (int i = 0; i < CHUNK_WIDTH; i++) c = c + ACC_W'(s[i]);
        return c;
    endfunction

    // The operand register shifts left one slice per RUN cycle, so the top slice is always the current one.
    assign w_slice       = r_a[DATA_WIDTH-1 -: CHUNK_WIDTH];
    assign w_popNext     = r_pop + slicePop(w_slice);
    assign w_parNext     = r_par ^ (^w_slice);
    assign w_lastChunk   = (r_cnt == CNT_W'(NUM_CHUNKS - 1));
    assign w_rotr        = (r_a >> r_amt) | (r_a << (DATA_WIDTH - int'(r_amt)));
    assign w_rotl        = (r_a << r_amt) | (r_a >> (DATA_WIDTH - int'(r_amt)));
    assign w_unusedBHigh = ^B_in[DATA_WIDTH-1:AMT_W];

`ifdef WIDE_BIT_ALU_CLZ_EN
    logic [ACC_W-1:0] r_clz;
    logic             r_found;
    logic [ACC_W-1:0] w_clzNext;

    // Highest set bit wins because the loop runs upward; an all-zero slice counts as a full slice.
    function automatic logic [ACC_W-1:0] sliceLz(input logic [CHUNK_WIDTH-1:0] s);
        logic [ACC_W-1:0] n;
        n = ACC_W'(CHUNK_WIDTH);
        for (int i = 0; i < CHUNK_WIDTH; i++) begin
            if (s[i]) n = ACC_W'(CHUNK_WIDTH - 1 - i);
        end
        return n;
    endfunction

    assign w_clzNext  = r_found ? r_clz : (r_clz + sliceLz(w_slice));
    assign w_isReduce = (r_op == OP_PARITY) || (r_op == OP_POPCOUNT) || (r_op == OP_CLZ);
`else
    assign w_isReduce = (r_op == OP_PARITY) || (r_op == OP_POPCOUNT);
`endif

    always_comb begin
        w_result = '0;
        w_err    = 1'b0;
        case (r_op)
            OP_PARITY:   w_result[0]       = w_parNext;
            OP_POPCOUNT: w_result[ACC_W-1:0] = w_popNext;
            OP_ROTR:     w_result          = w_rotr;
            OP_ROTL:     w_result          = w_rotl;
`ifdef WIDE_BIT_ALU_CLZ_EN
            OP_CLZ:      w_result[ACC_W-1:0] = w_clzNext;
`endif
            default:     w_err             = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_op       <= '0;
            r_a        <= '0;
            r_amt      <= '0;
            r_cnt      <= '0;
            r_pop      <= '0;
            r_par      <= 1'b0;
            r_outData  <= '0;
            r_outErr   <= 1'b0;
            r_outValid <= 1'b0;
`ifdef WIDE_BIT_ALU_CLZ_EN
            r_clz      <= '0;
            r_found    <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_op    <= opcode;
                        r_a     <= A_in;
                        r_amt   <= B_in[AMT_W-1:0];
                        r_cnt   <= '0;
                        r_pop   <= '0;
                        r_par   <= 1'b0;
`ifdef WIDE_BIT_ALU_CLZ_EN
                        r_clz   <= '0;
                        r_found <= 1'b0;
`endif
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_a   <= r_a << CHUNK_WIDTH;
                    r_cnt <= r_cnt + 1'b1;
                    r_pop <= w_popNext;
                    r_par <= w_parNext;
`ifdef WIDE_BIT_ALU_CLZ_EN
                    r_clz   <= w_clzNext;
                    r_found <= r_found | (|w_slice);
`endif
                    if (!w_isReduce || w_lastChunk) begin
                        r_outData  <= w_result;
                        r_outErr   <= w_err;
                        r_outValid <= 1'b1;
                        r_state    <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_outValid <= 1'b0;
                        r_state    <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_data  = r_outData;
    assign out_err   = r_outErr;
    assign out_valid = r_outValid;

endmodule

// File: tb/tb_wide_bit_alu.sv
// Directed self-checking bench for wide_bit_alu at DATA_WIDTH=64, CHUNK_WIDTH=16 (four slices).
// CLZ vectors follow WIDE_BIT_ALU_CLZ_EN so the same bench covers both builds.
module tb_wide_bit_alu;

    localparam int DW = 64;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [2:0]    opcode;
    logic [DW-1:0] A_in;
    logic [DW-1:0] B_in;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic          out_err;
    logic          out_valid;
    logic          out_ready;

    int numAsserts = 0;
    int numFail    = 0;

    wide_bit_alu #(.DATA_WIDTH(DW), .CHUNK_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .A_in(A_in), .B_in(B_in),
        .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
        .out_err(out_err), .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    // One comparison: counts it, and on mismatch counts and reports the failure.
    task automatic checkOutput(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        numAsserts++;
        assert (obs === exp) else begin
            numFail++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Presents a request and returns just after its accept edge, with the inputs scrambled.
    task automatic applyStimulus(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
        checkOutput("in_ready_before_accept", DW'(in_ready), DW'(1));
        opcode   = op;
        A_in     = a;
        B_in     = b;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        opcode   = 3'b111;
        A_in     = ~a;
        B_in     = {$urandom, $urandom};
    endtask

    // Waits (bounded) for the result, checks latency/data/err, then completes the handshake.
    task automatic waitResult(input string tag, input logic [DW-1:0] expData, input logic expErr, input int expLat);
        int lat = 0;
        while (out_valid !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        checkOutput({tag, "_latency"}, DW'(lat), DW'(expLat));
        checkOutput({tag, "_data"}, out_data, expData);
        checkOutput({tag, "_err"}, DW'(out_err), DW'(expErr));
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checkOutput({tag, "_valid_cleared"}, DW'(out_valid), DW'(0));
    endtask

    initial begin
        bit sawStale;
        rst       = 1'b1;
        opcode    = '0;
        A_in      = '0;
        B_in      = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("reset_in_ready", DW'(in_ready), DW'(1));
        checkOutput("reset_out_valid", DW'(out_valid), DW'(0));
        checkOutput("reset_out_data", out_data, '0);
        checkOutput("reset_out_err", DW'(out_err), DW'(0));

        applyStimulus(3'b001, 64'hFFFF_0000_0000_000F, 64'h0);
        waitResult("pop_20", 64'd20, 1'b0, 4);
        applyStimulus(3'b001, '1, 64'h0);
        waitResult("pop_all_ones", 64'd64, 1'b0, 4);

        applyStimulus(3'b000, 64'h1, 64'h0);
        waitResult("par_1", 64'd1, 1'b0, 4);
        applyStimulus(3'b000, 64'h3, 64'h0);
        waitResult("par_3", 64'd0, 1'b0, 4);
        applyStimulus(3'b000, 64'h8000_0000_0000_0001, 64'h0);
        waitResult("par_ends", 64'd0, 1'b0, 4);

        applyStimulus(3'b010, 64'h1, 64'd1);
        waitResult("rotr_1", 64'h8000_0000_0000_0000, 1'b0, 1);
        applyStimulus(3'b011, 64'h1, 64'd65);
        waitResult("rotl_wrap", 64'h2, 1'b0, 1);
        applyStimulus(3'b011, 64'hDEAD_BEEF_CAFE_F00D, 64'd0);
        waitResult("rotl_zero", 64'hDEAD_BEEF_CAFE_F00D, 1'b0, 1);
        applyStimulus(3'b010, 64'h0123_4567_89AB_CDEF, 64'd8);
        waitResult("rotr_8", 64'hEF01_2345_6789_ABCD, 1'b0, 1);

`ifdef WIDE_BIT_ALU_CLZ_EN
        applyStimulus(3'b100, 64'h0, 64'h0);
        waitResult("clz_zero", 64'd64, 1'b0, 4);
        applyStimulus(3'b100, 64'h0000_0100_0000_0000, 64'h0);
        waitResult("clz_23", 64'd23, 1'b0, 4);
        applyStimulus(3'b100, 64'h8000_0000_0000_0000, 64'h0);
        waitResult("clz_msb", 64'd0, 1'b0, 4);
`else
        applyStimulus(3'b100, 64'h1234, 64'h0);
        waitResult("clz_disabled", 64'd0, 1'b1, 1);
`endif
        applyStimulus(3'b111, 64'hFFFF, 64'h3);
        waitResult("illegal_111", 64'd0, 1'b1, 1);
        applyStimulus(3'b101, 64'hFFFF, 64'h3);
        waitResult("illegal_101", 64'd0, 1'b1, 1);

        // Backpressure: result held while a new request waits on the inputs.
        applyStimulus(3'b001, '1, 64'h0);
        for (int i = 0; i < 20 && out_valid !== 1'b1; i++) begin
            @(posedge clk); #1;
        end
        opcode   = 3'b011;
        A_in     = 64'h0123_4567_89AB_CDEF;
        B_in     = 64'd4;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checkOutput("bp_valid_held", DW'(out_valid), DW'(1));
            checkOutput("bp_data_held", out_data, 64'd64);
            checkOutput("bp_err_held", DW'(out_err), DW'(0));
            checkOutput("bp_in_ready_low", DW'(in_ready), DW'(0));
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checkOutput("bp_handshake_valid", DW'(out_valid), DW'(0));
        checkOutput("bp_handshake_ready", DW'(in_ready), DW'(1));
        @(posedge clk); #1;
        in_valid = 1'b0;
        checkOutput("bp_new_accepted", DW'(in_ready), DW'(0));
        waitResult("bp_rotl_4", 64'h1234_5678_9ABC_DEF0, 1'b0, 1);

        // Reset in the second RUN cycle of a popcount aborts it.
        applyStimulus(3'b001, '1, 64'h0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checkOutput("abort_out_valid", DW'(out_valid), DW'(0));
        checkOutput("abort_in_ready", DW'(in_ready), DW'(1));
        sawStale = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) sawStale = 1'b1;
        end
        checkOutput("abort_no_stale", DW'(sawStale), DW'(0));
        applyStimulus(3'b001, 64'hFF, 64'h0);
        waitResult("pop_after_abort", 64'd8, 1'b0, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", numAsserts, numFail);
        $finish;
    end

endmodule
